req_ack_mem_responder: RTL
==========================

Name: req_ack_mem_responder

Overview:
- Responder end of the level-request / acknowledge memory protocol used by the pixel engine: `read`/`readAcknowledge`/`readAddress`/`readData` plus `write`/`writeAcknowledge`/`writeAddress`/`writeData`.
- Serves requests from an on-chip block-RAM word store of 16-bit pixel words.
- Drop-in stand-in for the DDR controller, for simulation and for reduced-resolution builds.
- Arbitrates simultaneous read and write requests and models configurable access latency.

Parameters:
- ADDR_BITS, 15, number of low address bits decoded; store holds 2^ADDR_BITS words (covers 480 rows x 64 words).
- LATENCY, 2, cycles from request acceptance to acknowledge; legal range 1..15.
- INIT_WORD, 16'h0000, value every word holds after configuration (not re-applied by rst).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- read  in  1  read request level; held by requester until acknowledged.
- readAddress  in  24  word address for read; bits above ADDR_BITS ignored (see feature).
- readAcknowledge  out  1  one-cycle pulse: readData now valid.
- readData  out  16  read result; holds value until next read completes.
- write  in  1  write request level; held until acknowledged.
- writeAddress  in  24  word address for write.
- writeData  in  16  data to store; sampled at acceptance.
- writeAcknowledge  out  1  one-cycle pulse: write committed.
- busy  out  1  high from acceptance through the acknowledge cycle.
- errorCount  out  8  saturating count of out-of-range accesses; constant 0 when feature is compiled out.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - readAcknowledge=0, writeAcknowledge=0, readData=16'h0000, busy=0, errorCount=0.
  - FSM to IDLE, latency counter=0, lastServed=WRITE, so a read wins the first tie.
  - Store contents are not cleared.
- FSM states:
  - IDLE: if no request, stay. If exactly one of read/write is high, accept it. If both are high, accept the one not equal to lastServed (round-robin).
    - Acceptance latches address (low ADDR_BITS), writeData for writes, and op type.
    - Acceptance loads counter=LATENCY-1, sets busy=1, and moves to WAIT.
  - WAIT: decrement counter each cycle; on counter==0 go to ACK. With LATENCY=1, WAIT lasts one cycle.
  - ACK: perform the access.
    - Read: readData <= mem[addr] and readAcknowledge=1.
    - Write: mem[addr] <= data and writeAcknowledge=1.
    - Update lastServed and go to RECOVER.
  - RECOVER: one cycle, ignores both request inputs so a requester still holding its level is not re-served. busy deasserts here; go to IDLE.
- Timing: acknowledge asserts LATENCY+1 cycles after the accept edge. Minimum back-to-back service period is LATENCY+3 cycles.
- Acknowledge pulses are exactly one cycle. readAcknowledge and writeAcknowledge are never high together.
- Request inputs changing during WAIT are ignored; the latched address/data are used.
- A request deasserted before acknowledge is still completed and acknowledged (no abort).
- Read-after-write to the same address returns the newly written value.
- Reset mid-operation (WAIT or ACK): no acknowledge is issued. A write not yet in ACK is not committed. FSM returns to IDLE on the next cycle.
- errorCount saturates at 8'hFF.

Optional Feature:
- Macro: REQ_ACK_BOUNDS_CHECK_EN.
- Defined: an access is out-of-range if readAddress/writeAddress bits [23:ADDR_BITS] are nonzero.
  - Out-of-range read returns 16'hDEAD.
  - Out-of-range write is dropped and the store is unchanged.
  - Both are still acknowledged with normal timing and increment errorCount.
- Undefined: upper address bits are silently ignored (aliasing) and errorCount is tied to 0.

Decomposition:
- Shared package:
  - DATA_W=16, ADDR_W=24.
  - FSM state encoding: IDLE/WAIT/ACK/RECOVER.
  - Op-type enum: OP_READ/OP_WRITE.
  - Poison constant 16'hDEAD.
- One sub-module, req_ack_bram: single-port synchronous RAM, parameterised by ADDR_BITS/DATA_W/INIT_WORD, so synthesis infers block RAM. The FSM, arbitration and counters stay in the top.

Test Plan:
- Reset then write=1, writeAddress=24'h000100, writeData=16'hA5A5, LATENCY=2 -> writeAcknowledge pulses 3 cycles after accept for one cycle; busy high 4 cycles.
- Read 24'h000100 after the write -> readAcknowledge one cycle and readData=16'hA5A5, held through later idle cycles.
- read and write both held from IDLE after reset -> read served first, then write. Repeat with both held again -> write served first (alternation); never both acks in one cycle.
- Requester holds read for 2 cycles past readAcknowledge -> exactly one acknowledge, no duplicate service.
- rst asserted during WAIT of a write of 16'h1234 to 24'h000010 -> no writeAcknowledge; subsequent read of 24'h000010 returns the prior value (INIT_WORD).
- With REQ_ACK_BOUNDS_CHECK_EN: read of 24'h800000 -> readData=16'hDEAD, errorCount=1. Without it: same read aliases to word 0 and errorCount stays 0.

Source files
------------

// File: rtl/req_ack_mem_responder_pkg.sv
// Shared types and constants for the request/acknowledge memory responder.
package req_ack_mem_responder_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 24;

  localparam logic [DATA_W-1:0] POISON_WORD = 16'hDEAD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/req_ack_mem_responder_bram.sv
// Single-port synchronous word store; written so synthesis maps it onto block RAM.
module req_ack_bram #(
  parameter int ADDR_BITS = 15,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    dout
);

  // Contents come from configuration only; rst never touches the array.
  logic [DATA_W-1:0] mem [2**ADDR_BITS] = '{default: INIT_WORD};

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (en && !we) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/req_ack_mem_responder.sv
// Level-request / acknowledge memory responder backed by on-chip RAM.
// Optional bounds checking on upper address bits: define REQ_ACK_BOUNDS_CHECK_EN.
module req_ack_mem_responder
  import req_ack_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 15,
  parameter int LATENCY = 2,
  parameter logic [DATA_W-1:0] INIT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readAddress,
  output logic              readAcknowledge,
  output logic [DATA_W-1:0] readData,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  output logic              writeAcknowledge,
  output logic              busy,
  output logic [7:0]        errorCount
);

  localparam int CNT_W = 4;

  state_t             state, state_nxt;
  op_t                last_served, op_q;
  logic [CNT_W-1:0]   cnt;
  logic               take_read, take_write, take;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               ram_en, ram_we;
  logic [DATA_W-1:0]  ram_dout;
  logic               oob_ok;

  // Round-robin: on a tie the op not served last wins.
  always_comb begin
    state_nxt  = state;
    take_read  = 1'b0;
    take_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (read && (!write || last_served == OP_WRITE)) begin
          take_read = 1'b1;
          state_nxt = S_WAIT;
        end else if (write) begin
          take_write = 1'b1;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT:    if (cnt == '0) state_nxt = S_ACK;
      S_ACK:     state_nxt = S_RECOVER;
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign take = take_read || take_write;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Request capture: address/data/op are frozen for the whole transaction.
  always_ff @(posedge clk) begin
    if (take) begin
      op_q   <= take_read ? OP_READ : OP_WRITE;
      addr_q <= take_read ? readAddress[ADDR_BITS-1:0] : writeAddress[ADDR_BITS-1:0];
      data_q <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      busy             <= 1'b0;
      readAcknowledge  <= 1'b0;
      writeAcknowledge <= 1'b0;
      last_served      <= OP_WRITE;
    end else begin
      readAcknowledge  <= (state == S_ACK) && (op_q == OP_READ);
      writeAcknowledge <= (state == S_ACK) && (op_q == OP_WRITE);
      if (take) begin
        cnt  <= CNT_W'(LATENCY - 1);
        busy <= 1'b1;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_RECOVER) busy <= 1'b0;
      if (state == S_ACK) last_served <= op_q;
    end
  end

`ifdef REQ_ACK_BOUNDS_CHECK_EN
  logic oob_q, rd_poison;

  always_ff @(posedge clk) begin
    if (take) begin
      oob_q <= take_read ? (|(readAddress >> ADDR_BITS)) : (|(writeAddress >> ADDR_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errorCount <= '0;
      rd_poison  <= 1'b0;
    end else if (state == S_ACK) begin
      if (oob_q && errorCount != 8'hFF) errorCount <= errorCount + 8'd1;
      if (op_q == OP_READ) rd_poison <= oob_q;
    end
  end

  assign oob_ok   = !oob_q;
  assign readData = rd_poison ? POISON_WORD : ram_dout;
`else
  logic unused_upper;
  assign unused_upper = |{readAddress >> ADDR_BITS, writeAddress >> ADDR_BITS};
  assign oob_ok       = 1'b1;
  assign errorCount   = '0;
  assign readData     = ram_dout;
`endif

  // Access happens in ACK; reset in that cycle cancels it along with the acknowledge.
  assign ram_en = (state == S_ACK) && oob_ok && !rst;
  assign ram_we = (op_q == OP_WRITE);

  req_ack_bram #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_W   (DATA_W),
    .INIT_WORD(INIT_WORD)
  ) u_bram (
    .clk (clk),
    .rst (rst),
    .en  (ram_en),
    .we  (ram_we),
    .addr(addr_q),
    .din (data_q),
    .dout(ram_dout)
  );

endmodule
